// File: rtl/ysyx_22041207_shift_mul.sv
// ysyx_22041207_shift_mul: iterative shift-add RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Define YSYX_22041207_MUL_RADIX4_EN to consume two multiplier bits per cycle.
module ysyx_22041207_shift_mul #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      mul_op,
  input  logic            mulw,
  output logic            mul_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`ifdef YSYX_22041207_MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [6:0] N64 = 7'(XLEN / STEP);
  localparam logic [6:0] N32 = 7'(XLEN / (2 * STEP));
  state_t state, state_n;
  logic [6:0] cnt;
  logic [2*XLEN-1:0] acc, mc, pp, prod, ext;
  logic [XLEN-1:0] mb, ma_in, mb_in, sel;
  logic [1:0] op_r;
  logic neg, mulw_r, accept, last, na, nb;
`ifdef YSYX_22041207_MUL_RADIX4_EN
  logic [2*XLEN-1:0] mc3;
`endif
  always_comb begin
    na = !mulw && (mul_op == 2'b01 || mul_op == 2'b10) && a[XLEN-1];
    nb = !mulw && mul_op == 2'b01 && b[XLEN-1];
    ma_in = mulw ? XLEN'(a[31:0]) : na ? -a : a;
    mb_in = mulw ? XLEN'(b[31:0]) : nb ? -b : b;
    ext = (2*XLEN)'(ma_in);
    accept = state == IDLE && mul_valid && !flush;
    last = cnt == (mulw_r ? N32 : N64);
`ifdef YSYX_22041207_MUL_RADIX4_EN
    pp = mb[1] ? (mb[0] ? mc3 : mc << 1) : (mb[0] ? mc : '0);
`else
    pp = mb[0] ? mc : '0;
`endif
    prod = neg ? -acc : acc;
    sel = mulw_r ? {{32{prod[31]}}, prod[31:0]} : op_r == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    state_n = flush ? IDLE : state == IDLE ? (mul_valid ? BUSY : IDLE) : state == BUSY ? (last ? DONE : BUSY) : IDLE;
    mul_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // The extra BUSY cycle at cnt == N applies the sign correction and selects the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      mb <= '0;
      op_r <= '0;
      neg <= 1'b0;
      mulw_r <= 1'b0;
      result <= '0;
`ifdef YSYX_22041207_MUL_RADIX4_EN
      mc3 <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        mc <= ext;
        mb <= mb_in;
        acc <= '0;
        cnt <= '0;
        neg <= na ^ nb;
        op_r <= mul_op;
        mulw_r <= mulw;
`ifdef YSYX_22041207_MUL_RADIX4_EN
        mc3 <= (ext << 1) + ext;
`endif
      end else if (state == BUSY) begin
        if (last) begin
          acc <= prod;
          if (!flush) result <= sel;
        end else begin
          acc <= acc + pp;
          mc <= mc << STEP;
          mb <= mb >> STEP;
          cnt <= cnt + 7'd1;
`ifdef YSYX_22041207_MUL_RADIX4_EN
          mc3 <= mc3 << STEP;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041207_shift_mul.sv
// tb_ysyx_22041207_shift_mul: directed self-checking bench for the sequential multiplier.
module tb_ysyx_22041207_shift_mul;
`ifdef YSYX_22041207_MUL_RADIX4_EN
  localparam int L64 = 33;
  localparam int L32 = 17;
`else
  localparam int L64 = 65;
  localparam int L32 = 33;
`endif
  logic clk = 1'b0, rst = 1'b0, mul_valid = 1'b0, flush = 1'b0, mulw = 1'b0;
  logic [63:0] a = '0, b = '0, result;
  logic [1:0] mul_op = '0;
  logic mul_ready, out_valid;
  int vecs = 0, miss = 0;

  ysyx_22041207_shift_mul dut (
    .clk(clk), .rst(rst), .mul_valid(mul_valid), .flush(flush), .a(a), .b(b),
    .mul_op(mul_op), .mulw(mulw), .mul_ready(mul_ready), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle, then scrambles the inputs to prove they are latched.
  task automatic start(input logic [1:0] op, input logic w, input logic [63:0] x, input logic [63:0] y);
    mul_op = op;
    mulw = w;
    a = x;
    b = y;
    mul_valid = 1'b1;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    a = ~x;
    b = ~y;
    mul_op = ~op;
    mulw = ~w;
  endtask

  task automatic finish(input string tag, input logic [63:0] exp, input int lat, input int k0);
    int k = k0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!out_valid && k < 200);
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " result"}, result, exp);
    @(posedge clk);
    #1;
    check({tag, " pulse width"}, {62'b0, out_valid, mul_ready}, 64'b01);
  endtask

  task automatic quiet(input string tag, input int n);
    int p = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (out_valid) p++;
    end
    check(tag, 64'(p), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {mul_ready, out_valid, result}, {2'b10, 64'd0});
    rst = 1'b1;
    @(posedge clk);
    #1;

    start(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    check("mul busy ready", {63'b0, mul_ready}, 64'd0);
    finish("mul 3*-5", 64'hFFFF_FFFF_FFFF_FFF1, L64, 0);
    start(2'b11, 1'b0, '1, '1);
    finish("mulhu ones", 64'hFFFF_FFFF_FFFF_FFFE, L64, 0);
    start(2'b01, 1'b0, '1, '1);
    finish("mulh ones", 64'h0, L64, 0);
    start(2'b10, 1'b0, '1, 64'd2);
    finish("mulhsu -1*2", 64'hFFFF_FFFF_FFFF_FFFF, L64, 0);
    start(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    finish("mulh min*min", 64'h4000_0000_0000_0000, L64, 0);
    start(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    finish("mul min*min", 64'h0, L64, 0);
    start(2'b11, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2);
    finish("mulw", 64'hFFFF_FFFF_FFFF_FFFE, L32, 0);

    // Flush raised during the 10th BUSY cycle.
    start(2'b00, 1'b0, 64'd7, 64'd9);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy ready", {62'b0, out_valid, mul_ready}, 64'b01);
    quiet("flush busy no valid", L64 + 5);
    check("flush result held", result, 64'hFFFF_FFFF_FFFF_FFFE);
    start(2'b11, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000);
    finish("mulhu 2^32*2^32", 64'h1, L64, 0);

    // Flush together with a request in IDLE.
    mul_valid = 1'b1;
    flush = 1'b1;
    a = 64'd5;
    b = 64'd5;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    flush = 1'b0;
    check("flush idle not accepted", {63'b0, mul_ready}, 64'd1);
    quiet("flush idle no valid", L64 + 5);

    // Reset pulse in the middle of an operation.
    start(2'b00, 1'b0, 64'd11, 64'd13);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async reset", {mul_ready, out_valid, result}, {2'b10, 64'd0});
    #1;
    rst = 1'b1;
    quiet("reset no valid", L64 + 5);
    check("reset result", result, 64'd0);

    // A request presented while BUSY is ignored.
    start(2'b11, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000);
    repeat (4) @(posedge clk);
    #1;
    mul_valid = 1'b1;
    mul_op = 2'b00;
    a = 64'd5;
    b = 64'd7;
    @(posedge clk);
    #1;
    mul_valid = 1'b0;
    check("busy ready low", {63'b0, mul_ready}, 64'd0);
    finish("busy req ignored", 64'h1, L64, 5);
    quiet("no second result", L64 + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
